// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one 4-bit ALU.
// Results come back registered, tagged with the requester id, on a response channel that supports backpressure.
module alu_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [3:0]       rsp_res,
   output logic             rsp_car,
   output logic             rsp_of,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state;
   logic       last_gnt;
   logic       pick1;
   logic       grant;
   logic [2:0] op_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       id_q;
   logic [4:0] sum;
   logic [4:0] diff;
   logic [3:0] alu_res;
   logic       alu_car;
   logic       alu_of;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // a requester holds valid and operands stable until it sees ready, and
   // rsp_* stay frozen while rsp_valid is high and rsp_ready is low.
   assign pick1      = req1_valid && (!req0_valid || !last_gnt);
   assign grant      = (state == IDLE) && !rst;
   assign req0_ready = grant && req0_valid && !pick1;
   assign req1_ready = grant && pick1;
   assign dbg_state  = state;

   always_comb begin
      sum     = {1'b0, a_q} + {1'b0, b_q};
      diff    = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
      alu_res = 4'h0;
      alu_car = 1'b0;
      alu_of  = 1'b0;
      case (op_q)
         3'b000: begin
            alu_res = sum[3:0];
            alu_car = sum[4];
            alu_of  = (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
         end
         3'b001: begin
            alu_res = diff[3:0];
            alu_car = diff[4];
            alu_of  = (a_q[3] != b_q[3]) && (diff[3] != a_q[3]);
         end
         3'b010:  alu_res = ~a_q;
         3'b011:  alu_res = a_q & b_q;
         3'b100:  alu_res = a_q | b_q;
         3'b101:  alu_res = a_q ^ b_q;
         3'b110:  alu_res = ($signed(a_q) < $signed(b_q)) ? 4'b0001 : 4'b0000;
         default: alu_res = (a_q == b_q) ? 4'b0001 : 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         op_q      <= 3'd0;
         a_q       <= 4'd0;
         b_q       <= 4'd0;
         id_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_res   <= 4'd0;
         rsp_car   <= 1'b0;
         rsp_of    <= 1'b0;
         gnt_cnt0  <= '0;
         gnt_cnt1  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  op_q     <= pick1 ? req1_op : req0_op;
                  a_q      <= pick1 ? req1_a : req0_a;
                  b_q      <= pick1 ? req1_b : req0_b;
                  id_q     <= pick1;
                  last_gnt <= pick1;
                  // Counters stick at all-ones rather than wrapping.
                  if (pick1) begin
                     if (gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
                  end else begin
                     if (gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
                  end
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_res   <= alu_res;
               rsp_car   <= alu_car;
               rsp_of    <= alu_of;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester front end that shares one 4-bit combinational ALU between two clients. It arbitrates round-robin and latches the winner's operands. It executes the operation, then returns a registered result tagged with the requester id over a valid/ready response channel with backpressure. It also keeps per-requester grant counters for debug/perf readout.

Parameters:
CNT_W, 8, width of each saturating grant counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an op pending
req0_ready  output  1  requester 0 op accepted this cycle
req0_op  input  3  requester 0 opcode
req0_a  input  4  requester 0 operand a
req0_b  input  4  requester 0 operand b
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that issued the op
rsp_res  output  4  result
rsp_car  output  1  carry flag
rsp_of  output  1  signed overflow flag
gnt_cnt0  output  CNT_W  grants given to requester 0, saturating
gnt_cnt1  output  CNT_W  grants given to requester 1, saturating

Behaviour:
- One clock domain; everything sampled on the rising edge of clk.
- rst is synchronous and active-high. It overrides all other activity, including a reset in the middle of an op; an in-flight op is dropped with no response.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_car=0, rsp_of=0
  - gnt_cnt0=0, gnt_cnt1=0
  - last_gnt=1, so requester 0 wins the first tie
- FSM IDLE -> EXEC -> RESP -> IDLE:
  - IDLE: if any reqN_valid, grant one requester. reqN_ready=1 for the granted requester only, combinationally in that cycle. Latch op/a/b/id, update last_gnt, increment its counter, go to EXEC. If no requester is valid, stay in IDLE.
  - EXEC: drive the latched operands to the ALU and register res/car/of/id into the rsp_* outputs. Set rsp_valid=1 and go to RESP.
  - RESP: hold all rsp_* outputs stable while rsp_ready=0. On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
- req*_ready is 0 in EXEC and RESP. Requesters must hold valid and operands until they see ready.
- Latency: accept in cycle t, rsp_valid high from t+2. Best-case throughput is one op per 3 cycles, when rsp_ready is tied high.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester != last_gnt wins.
  - A non-granted valid request stays pending; it is never lost.
- Counters increment by one per grant and saturate at 2^CNT_W-1; they do not wrap.
- ALU op encoding (car=of=0 unless stated):
  - 000 add: {car,res}=a+b; of=(a[3]==b[3])&&(res[3]!=a[3]).
  - 001 sub: {car,res}=a+(~b)+1 in 5 bits; of=(a[3]!=b[3])&&(res[3]!=a[3]).
  - 010 not: res=~a.
  - 011 and: res=a&b.
  - 100 or: res=a|b.
  - 101 xor: res=a^b.
  - 110 signed less-than: res=4'b0001 if $signed(a)<$signed(b), else 0.
  - 111 equal: res=4'b0001 if a==b, else 0.
- The block is fully combinationally latch-free; every output is a flop or a pure decode of state/inputs.

Test Plan:
- Reset, then idle with no requests -> all rsp_* 0, both readies 0, counters 0, state stays IDLE.
- req0 add a=7 b=1, rsp_ready=1 -> req0_ready in accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, res=8, car=0, of=1.
- req1 sub a=0 b=1 -> rsp_id=1, res=F, car=0, of=0. Then slt a=F b=1 -> res=1. Then eq a=5 b=5 -> res=1.
- Both valid continuously, rsp_ready=1, 4 ops -> grant order 0,1,0,1; gnt_cnt0=2, gnt_cnt1=2; each requester's operands returned with the correct rsp_id.
- rsp_ready held 0 for 5 cycles during RESP -> rsp_* stable; req ready stays 0; after rsp_ready=1, one handshake, then IDLE.
- Assert rst in EXEC with a request pending -> next cycle all outputs at reset values, no response emitted. Also, with CNT_W=2, 5 grants to req0 -> gnt_cnt0=3 (saturated).
